// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and block-memory handshake signals around mem_arbiter.
// The arbiter uses the slave view; the cache/memory environment uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block data memory between the I-cache (read-only)
// and the D-cache (read/write); one latched block transfer at a time.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t            state;
  port_t             gnt;
  port_t             last;
  port_t             winner;
  logic              started;
  logic              op_wr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic req_i;
  logic req_d;
  logic in_serve;
  logic done;

  assign req_i    = bus.i_read;
  assign req_d    = bus.d_read | bus.d_write;
  assign in_serve = (state == SERVE);
  // started guarantees the memory has acknowledged the strobe before we trust busywait low
  assign done     = in_serve & started & ~bus.mem_busywait;

  always_comb begin
    winner = PORT_D;
    if (req_i && req_d)
      winner = (last == PORT_I) ? PORT_D : PORT_I;
    else if (req_i)
      winner = PORT_I;
  end

  assign bus.mem_read      = in_serve & ~op_wr;
  assign bus.mem_write     = in_serve & op_wr;
  assign bus.mem_address   = in_serve ? op_addr : '0;
  assign bus.mem_writedata = (in_serve && op_wr) ? op_wdata : '0;

  assign bus.i_busywait = req_i & ~(done & (gnt == PORT_I));
  assign bus.d_busywait = req_d & ~(done & (gnt == PORT_D));
  assign bus.i_readdata = i_rdata_q;
  assign bus.d_readdata = d_rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= PORT_I;
      last      <= PORT_D;
      started   <= 1'b0;
      op_wr     <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i || req_d) begin
            gnt     <= winner;
            last    <= winner;
            started <= 1'b0;
            state   <= SERVE;
            if (winner == PORT_I) begin
              op_wr    <= 1'b0;
              op_addr  <= bus.i_address;
              op_wdata <= '0;
            end else begin
              op_wr    <= bus.d_write;
              op_addr  <= bus.d_address;
              op_wdata <= bus.d_writedata;
            end
          end
        end
        SERVE: begin
          if (bus.mem_busywait)
            started <= 1'b1;
          if (done) begin
            if (!op_wr) begin
              if (gnt == PORT_I)
                i_rdata_q <= bus.mem_readdata;
              else
                d_rdata_q <= bus.mem_readdata;
            end
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 128-bit block data memory between the instruction cache (read-only port I) and the data cache (read/write port D). It sits between the caches' miss/write-back FSMs and `data_memory`. Toward each cache it presents the same `read/write/address/writedata/readdata/busywait` protocol the caches already use on the memory. Requests are granted round-robin, one block transfer at a time. The granted command is latched, so the memory sees a stable request for the whole transfer.

## Interface
- `ADDR_W`, 28: block address width (byte address bits [31:4]).
- `DATA_W`, 128: block width.
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `i_read`  in  1  I-port block read request; level, held until `i_busywait` low.
- `i_address`  in  ADDR_W  I-port block address.
- `i_readdata`  out  DATA_W  registered block returned to I.
- `i_busywait`  out  1  I-port stall.
- `d_read`, `d_write`  in  1 each  D-port request; both high is treated as write.
- `d_address`  in  ADDR_W  D-port block address.
- `d_writedata`  in  DATA_W  D-port write-back block.
- `d_readdata`  out  DATA_W  registered block returned to D.
- `d_busywait`  out  1  D-port stall.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `mem_address`  out  ADDR_W  memory block address.
- `mem_writedata`  out  DATA_W  memory write block.
- `mem_readdata`  in  DATA_W  memory read block; valid when `mem_busywait` falls.
- `mem_busywait`  in  1  memory busy.

## Operation
- Request terms: `req_i = i_read`; `req_d = d_read | d_write`.
- State machine: IDLE, SERVE, RELEASE. Registers: `gnt` (I/D), `last` (I/D), `started`, latched `op_wr`, `op_addr`, `op_wdata`.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner. If only one port requests, that port wins. If both request, the port ≠ `last` wins.
  - At the edge: set `gnt` = winner and `last` = winner. Latch `op_wr`, `op_addr` and `op_wdata` from the winner (I: `op_wr=0`, `op_wdata=0`). Clear `started`. Go to SERVE.
- SERVE:
  - `mem_read = !op_wr`, `mem_write = op_wr`, `mem_address = op_addr`, `mem_writedata = op_wr ? op_wdata : 0`.
  - `started` sets at the edge of any SERVE cycle in which `mem_busywait = 1`.
  - `done = started & !mem_busywait`.
  - On `done`: at the edge, load `mem_readdata` into the granted port's readdata register (reads only; writes leave it unchanged), then go to RELEASE.
- RELEASE: all mem outputs 0 for exactly one cycle so the memory sees the strobe drop; then IDLE.
- Outside SERVE, `mem_read`, `mem_write`, `mem_address` and `mem_writedata` are 0, never X.
- Busywait, combinational:
  - `i_busywait = req_i & !(state==SERVE & gnt==I & done)`.
  - `d_busywait` is the same with D.
  - A requester therefore sees busywait low only in its completion cycle. If it re-requests during RELEASE or IDLE, it stalls again.
- Readdata registers hold their value until that port's next read completion.
- Request dropped during SERVE: illegal for the caches. The arbiter still finishes the latched transfer, and the port's busywait follows `req` (low).
- `d_address`/`d_writedata` changing during SERVE has no effect (latched).

## Timing
- Reset (async, immediate):
  - state = IDLE, `last` = D (I wins the first tie), `started` = 0.
  - `i_readdata` = `d_readdata` = 0; all mem outputs 0.
  - Busywaits = the respective `req` terms.
- Request seen in IDLE at cycle 0: mem strobe is high from cycle 1.
- Memory busy for N ≥ 1 cycles starting cycle 1: `done` occurs in cycle N+1, and the requester's busywait is low in that cycle only.
- Readdata is valid from cycle N+2. RELEASE is cycle N+2, IDLE is cycle N+3.
- Arbiter overhead per transfer: 1 grant cycle + 1 release cycle.
- Next grant decision is made in cycle N+3, so the losing port's strobe rises no earlier than cycle N+4.
- `mem_busywait` never high in SERVE: the arbiter waits in SERVE indefinitely, by design, because the memory always stalls ≥ 1 cycle.
- Reset asserted mid-SERVE: strobes drop immediately, and the partially served port gets no readdata update. After reset it re-arbitrates from IDLE.

## Test plan
- Single I read, addr 0x0000010, memory 5-cycle latency returning 0xAAAA…: `mem_read` high cycles 1–6, `i_busywait` low only in cycle 6, `i_readdata = 0xAAAA…` from cycle 7, `mem_read` 0 in cycle 7.
- D write-back then refill (dcache dirty miss) to 0x0000020 with data 0x1234…: `mem_write` with latched data, then `d_busywait` rises again during RELEASE. The read follows with `mem_read`; `d_readdata` is updated and unchanged by the write.
- Simultaneous I and D requests from reset: I served first. With both held continuously, grants alternate I, D, I, D over 4 transfers.
- Change `d_address` and `d_writedata` mid-SERVE: `mem_address`/`mem_writedata` stay at the latched values (check every cycle).
- Assert reset in cycle 3 of a D read: `mem_read` is 0 in the same cycle, `d_readdata` = 0. After release, D is re-granted and completes normally.
- Idle with no requests: all outputs 0, busywaits 0, and the state stays IDLE for 20 cycles.
